// File: rtl/mandel_iter_ctrl.sv
// Escape-time iteration controller: z(n+1) = z(n)^2 + c from z(0) = 0.
// One shared squaring/magnitude stage per iteration: MUL registers z*z and
// |z|^2, ACC tests for escape or limit and otherwise advances z and the count.
module mandel_iter_ctrl #(
  parameter int ws = 16,
  parameter int dp = 8,
  parameter int iw = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*ws-1:0] c,
  input  logic [iw-1:0]   max_iter,
  output logic            busy,
  output logic            done,
  output logic [iw-1:0]   iter,
  output logic            escaped
);

  typedef enum logic [1:0] {IDLE, MUL, ACC, FIN} state_t;

  localparam logic signed [ws-1:0] FOUR = ws'(4 << dp);

  state_t state, state_nx;

  logic signed [ws-1:0] z_re, z_im;
  logic signed [ws-1:0] c_re, c_im;
  logic signed [ws-1:0] sq_re, sq_im;
  logic signed [ws-1:0] mag;
  logic [iw-1:0]        lim, cnt, iter_r;
  logic                 esc_r;

  logic signed [ws-1:0] rr, ii, ri;
  logic signed [ws-1:0] sq_re_nx, sq_im_nx, mag_nx;
  logic                 escape, at_lim;

  // Fixed-point product: full-width signed multiply, arithmetic shift, wrap to ws.
  function automatic logic signed [ws-1:0] fx_mul(input logic signed [ws-1:0] a,
                                                  input logic signed [ws-1:0] b);
    logic signed [2*ws-1:0] p;
    p = (2*ws)'(a) * (2*ws)'(b);
    return ws'(p >>> dp);
  endfunction

  // Squaring datapath and escape test; the imaginary part is the sum of the two
  // identical cross products of a complex multiply, each truncated separately.
  always_comb begin
    rr       = fx_mul(z_re, z_re);
    ii       = fx_mul(z_im, z_im);
    ri       = fx_mul(z_re, z_im);
    sq_re_nx = rr - ii;
    sq_im_nx = ri + ri;
    mag_nx   = rr + ii;
    escape   = mag[ws-1] || (mag > FOUR);
    at_lim   = (cnt == lim);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = MUL;
      MUL: begin
        busy     = 1'b1;
        state_nx = ACC;
      end
      ACC: begin
        busy     = 1'b1;
        state_nx = (escape || at_lim) ? FIN : MUL;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers: capture on accept, square in MUL, advance or finish in ACC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_re   <= '0;
      z_im   <= '0;
      c_re   <= '0;
      c_im   <= '0;
      sq_re  <= '0;
      sq_im  <= '0;
      mag    <= '0;
      lim    <= '0;
      cnt    <= '0;
      iter_r <= '0;
      esc_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          c_re <= c[ws-1:0];
          c_im <= c[2*ws-1:ws];
          lim  <= max_iter;
          z_re <= '0;
          z_im <= '0;
          cnt  <= '0;
        end
        MUL: begin
          sq_re <= sq_re_nx;
          sq_im <= sq_im_nx;
          mag   <= mag_nx;
        end
        ACC: begin
          if (escape) begin
            esc_r  <= 1'b1;
            iter_r <= cnt;
          end else if (at_lim) begin
            esc_r  <= 1'b0;
            iter_r <= cnt;
          end else begin
            z_re <= sq_re + c_re;
            z_im <= sq_im + c_im;
            cnt  <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign iter    = iter_r;
  assign escaped = esc_r;

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Directed bench for mandel_iter_ctrl: vector table of points with hand-computed
// results and start-to-done latency, plus start-ignore and mid-run reset sequences.
module tb_mandel_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] c;
  logic [7:0]  max_iter;
  logic        busy, done, escaped;
  logic [7:0]  iter;

  int n_cmp = 0;
  int n_bad = 0;

  mandel_iter_ctrl #(.ws(16), .dp(8), .iw(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c), .max_iter(max_iter),
    .busy(busy), .done(done), .iter(iter), .escaped(escaped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic [7:0]  mi;
    int          e_iter;
    int          e_esc;
    int          e_lat;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with start already driven; edge 0 is the next posedge.
  // Latency counts posedges from edge 0 inclusive until done is visible.
  task automatic wait_done(input string name, input int e_iter, input int e_esc,
                           input int e_lat, input int glitch_at,
                           input logic [31:0] gc, input logic [7:0] gm);
    int n;
    bit busy_ok;
    bit seen;
    busy_ok = 1'b1;
    seen    = 1'b0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    while (n < 2000) begin
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (n == glitch_at) begin
        start    = 1'b1;
        c        = gc;
        max_iter = gm;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({name, " done_seen"}, int'(seen), 1);
    chk({name, " iter"}, int'(iter), e_iter);
    chk({name, " escaped"}, int'(escaped), e_esc);
    chk({name, " latency"}, n, e_lat);
    chk({name, " busy_until_done"}, int'(busy_ok) & int'(!busy), 1);
  endtask

  initial begin
    tv[0] = '{32'h0000_0100, 8'd255,   3, 1,   9};  // 1.0: 0,1,2,5
    tv[1] = '{32'h0000_0200, 8'd255,   2, 1,   7};  // 2.0: mag 4.0 holds, then 6
    tv[2] = '{32'h0000_0000, 8'd255, 255, 0, 513};  // origin never escapes
    tv[3] = '{32'h0000_FF00, 8'd10,   10, 0,  23};  // -1.0 oscillates
    tv[4] = '{32'h1234_5678, 8'd0,     0, 0,   3};  // limit 0
    tv[5] = '{32'h0100_0000, 8'd20,   20, 0,  43};  // i: cycles -1+i / -i
    tv[6] = '{32'h0000_FE00, 8'd5,     5, 0,  13};  // -2.0: mag exactly 4 forever
    tv[7] = '{32'h0000_0201, 8'd255,   1, 1,   5};  // mag 0x404 just over 4.0
    tv[8] = '{32'h0000_0C00, 8'd255,   1, 1,   5};  // 12.0: mag wraps negative
    tv[9] = '{32'h0000_FD00, 8'd255,   1, 1,   5};  // -3.0: mag 9

    rst_n = 1'b0; start = 1'b0; c = '0; max_iter = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset iter", int'(iter), 0);
    chk("reset escaped", int'(escaped), 0);

    for (int i = 0; i < 10; i++) begin
      c = tv[i].c; max_iter = tv[i].mi; start = 1'b1;
      wait_done($sformatf("vec%0d", i), tv[i].e_iter, tv[i].e_esc, tv[i].e_lat,
                0, '0, '0);
      @(negedge clk);
    end

    // Start pulsed mid-run must not disturb the running point.
    c = 32'h0000_0100; max_iter = 8'd255; start = 1'b1;
    wait_done("midrun", 3, 1, 9, 4, 32'h0000_0300, 8'd0);
    // Now in the FIN cycle: a start here is ignored, the next cycle accepts it.
    c = 32'h0000_0200; max_iter = 8'd255; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fin_start busy", int'(busy), 0);
    chk("fin_start done", int'(done), 0);
    chk("fin_start iter_held", int'(iter), 3);
    wait_done("after_fin", 2, 1, 7, 0, '0, '0);
    @(negedge clk);

    // Reset during MUL of iteration 2 (cycle after edge 4).
    c = 32'h0000_0100; max_iter = 8'd255; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_reset busy", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset iter", int'(iter), 0);
    chk("midreset escaped", int'(escaped), 0);
    begin
      bit any_done;
      any_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done || busy) any_done = 1'b1;
      end
      chk("midreset no_done", int'(any_done), 0);
    end
    c = 32'h0000_0300; max_iter = 8'd255; start = 1'b1;
    wait_done("post_reset", 1, 1, 5, 0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mandel_iter_ctrl.md
# mandel_iter_ctrl

Sequencing controller for the fixed-point complex datapath: runs the escape-time iteration z(n+1) = z(n)^2 + c for one point c, starting from z(0) = 0. It reuses one complex multiplier and one |z|^2 unit every iteration, and reports the iteration count at which |z|^2 first exceeds 4.0 or the iteration limit is hit. It sits between the pixel scanner and the colour mapper, one point in flight at a time.

## Interface

Parameters:
- ws, 16: fixed-point word size. A complex value is 2*ws bits, packed {im, re}; each half is two's complement.
- dp, 8: fractional bits per half.
- iw, 8: width of the iteration counter and the limit.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset. Synchronous, active-low.
- start  input  1  request a new point. Sampled only while busy=0.
- c  input  2*ws  point to iterate, {im, re}. Captured on an accepted start.
- max_iter  input  iw  iteration limit. Captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse: the result is valid.
- iter  output  iw  final iteration count. Held until the next accepted start.
- escaped  output  1  1 means |z|^2 exceeded 4.0; 0 means the limit was reached. Held like iter.

## Operation

Internal registers:
- z: complex, 2*ws.
- c_r: captured c.
- lim: captured max_iter.
- cnt: iteration counter, iw bits.
- sq: registered z*z.
- mag: registered |z|^2, ws bits.

Arithmetic:
- Every product is (a*b) >>> dp, truncated to ws bits.
- All adds and subtracts wrap at ws bits. No saturation.
- sq = {2*re*im, re*re - im*im}, using the complex-multiply structure with both operands equal to z.
- mag = re*re + im*im, with wrap.

Escape test:
- Escape when mag > 4.0, i.e. mag > (4 << dp) compared as signed.
- Escape also when mag is negative (sign bit set). This treats overflow as an escape.

FSM states: IDLE, MUL, ACC, FIN.
- IDLE: busy=0. When start=1: c_r<=c, lim<=max_iter, z<=0, cnt<=0, go to MUL.
- MUL: sq<=z*z, mag<=|z|^2, go to ACC.
- ACC, in priority order:
  - If escape: escaped<=1, iter<=cnt, go to FIN.
  - Else if cnt==lim: escaped<=0, iter<=cnt, go to FIN.
  - Else: z<=sq+c_r (re and im added separately, wrapping), cnt<=cnt+1, go to MUL.
- FIN: done=1 for this one cycle, busy=0, go to IDLE.

Boundary conditions:
- start while busy: ignored. It is not queued.
- start=1 in the FIN cycle: ignored. It is accepted from IDLE only, so the earliest re-accept is the cycle after done.
- max_iter=0: the single check of z(0)=0 finishes with iter=0, escaped=0.
- cnt cannot wrap: the limit check stops it at lim, and lim is at most 2^iw - 1.
- mag exactly 4.0: not an escape.
- Reset at any point, including mid-iteration:
  - next state is IDLE;
  - busy=0, done=0, iter=0, escaped=0;
  - z, cnt, sq and mag are cleared.

## Timing

- Edge 0 is the rising edge that samples start=1 in IDLE.
- The check of z(k) happens on ACC edge 2k+2.
- A point finishing at count k raises done in the cycle after edge 2k+2. That is 2k+3 cycles from start to done.
- busy is high from the cycle after edge 0 through the last ACC cycle.
- iter and escaped update on the same edge that enters FIN, so they are valid while done=1 and stay stable afterwards.
- Throughput: one point per 2k+4 cycles when start is held high.
- Values after reset: done=0, busy=0, iter=0, escaped=0.

## Test plan

- c=0x0000_0100 (1.0+0j), max_iter=255 -> z runs 0, 1, 2, 5. done pulses 9 cycles after start with iter=3, escaped=1 (mag 25.0 > 4).
- c=0x0000_0200 (2.0+0j), max_iter=255 -> z(1)=2, whose mag of exactly 4.0 does not escape. z(2)=6 escapes, giving iter=2, escaped=1.
- c=0, max_iter=255 -> never escapes. iter=255, escaped=0, done 513 cycles after start. busy stays high for all cycles between start and done.
- c=0x0000_FF00 (-1.0), max_iter=10 -> z oscillates between 0 and -1. Result iter=10, escaped=0. Then c=anything with max_iter=0 -> iter=0, escaped=0, done 3 cycles after start.
- start pulsed again mid-run for c=1.0 -> the pulse is ignored and the first result is unchanged (iter=3). A start asserted in the FIN cycle is also ignored. A start in the next cycle is accepted.
- rst_n=0 for one cycle during MUL of iteration 2 -> the next cycle shows IDLE with busy=0, done=0, iter=0, escaped=0, and no done pulse follows. A fresh start then produces the correct result.
